// File: rtl/dual_path_delay.sv
// dual_path_delay: one input feeding two register chains of equal depth.
// Path 1 loads every stage from d on each edge, so q1 lags d by one clock.
// Path 2 is a shift register, so q2 lags d by DEPTH clocks.
// fill goes high once DEPTH samples have been shifted in since the last reset.
module dual_path_delay #(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic             diff,
    output logic             fill
);

    // The counter must be able to hold the value DEPTH.
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] s1 [DEPTH];
    logic [WIDTH-1:0] s2 [DEPTH];
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;

    // Collapsed chain: every stage takes d on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                s1[i] <= RST_VAL;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                s1[i] <= d;
            end
        end
    end

    // True pipeline: each stage takes the previous stage's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                s2[i] <= RST_VAL;
            end
        end else begin
            s2[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                s2[i] <= s2[i-1];
            end
        end
    end

    // Saturating sample count; holds at DEPTH rather than wrapping.
    always_comb begin
        count_nxt = count;
        if (count != CW'(DEPTH)) begin
            count_nxt = count + CW'(1);
        end
    end

    // Fill counter and registered fill flag, which tracks count == DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            fill  <= 1'b0;
        end else begin
            count <= count_nxt;
            fill  <= (count_nxt == CW'(DEPTH));
        end
    end

    assign q1   = s1[DEPTH-1];
    assign q2   = s2[DEPTH-1];

    // diff is the only unregistered output; it depends only on the registered q1 and q2.
    assign diff = (q1 != q2);

endmodule

// File: tb/tb_dual_path_delay.sv
// Bench for dual_path_delay: three configurations share one clock and one reset.
// Each configuration is checked every cycle against a history-based model.
//   a: WIDTH=1 DEPTH=2 RST_VAL=0
//   b: WIDTH=8 DEPTH=4 RST_VAL=8'h5A
//   c: WIDTH=1 DEPTH=1 RST_VAL=0
module tb_dual_path_delay;

    logic       clk;
    logic       rst;
    logic       da;
    logic [7:0] db;
    logic       dc;
    logic       qa1, qa2, diffa, filla;
    logic [7:0] qb1, qb2;
    logic       diffb, fillb;
    logic       qc1, qc2, diffc, fillc;

    int checks   = 0;
    int failures = 0;

    // Model state: hist[k][j] is the d value sampled j edges ago.
    // n[k] is the number of non-reset edges since the last reset.
    logic [7:0] hist [3][16];
    int         n    [3];
    int         dep  [3];
    logic [7:0] rv   [3];

    dual_path_delay #(.WIDTH(1), .DEPTH(2), .RST_VAL(1'b0)) u_a (
        .clk(clk), .rst(rst), .d(da), .q1(qa1), .q2(qa2), .diff(diffa), .fill(filla));
    dual_path_delay #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h5A)) u_b (
        .clk(clk), .rst(rst), .d(db), .q1(qb1), .q2(qb2), .diff(diffb), .fill(fillb));
    dual_path_delay #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) u_c (
        .clk(clk), .rst(rst), .d(dc), .q1(qc1), .q2(qc2), .diff(diffc), .fill(fillc));

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] dval(input int k);
        if (k == 0) return {7'b0, da};
        if (k == 1) return db;
        return {7'b0, dc};
    endfunction

    function automatic logic [7:0] act_q1(input int k);
        if (k == 0) return {7'b0, qa1};
        if (k == 1) return qb1;
        return {7'b0, qc1};
    endfunction

    function automatic logic [7:0] act_q2(input int k);
        if (k == 0) return {7'b0, qa2};
        if (k == 1) return qb2;
        return {7'b0, qc2};
    endfunction

    function automatic logic act_diff(input int k);
        if (k == 0) return diffa;
        if (k == 1) return diffb;
        return diffc;
    endfunction

    function automatic logic act_fill(input int k);
        if (k == 0) return filla;
        if (k == 1) return fillb;
        return fillc;
    endfunction

    // Compare every output of every instance against the model.
    task automatic check_all();
        logic [7:0] e1, e2;
        string      nm;
        for (int k = 0; k < 3; k++) begin
            e1 = (n[k] >= 1) ? hist[k][0] : rv[k];
            e2 = (n[k] >= dep[k]) ? hist[k][dep[k]-1] : rv[k];
            nm = (k == 0) ? "a" : (k == 1) ? "b" : "c";
            chk({nm, "_q1"},   act_q1(k), e1);
            chk({nm, "_q2"},   act_q2(k), e2);
            chk({nm, "_diff"}, {7'b0, act_diff(k)}, {7'b0, (e1 != e2)});
            chk({nm, "_fill"}, {7'b0, act_fill(k)}, {7'b0, (n[k] >= dep[k])});
        end
    endtask

    // One clock: update the model with the values present at the rising edge,
    // then check on the falling edge.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                n[k] = 0;
            end else begin
                for (int j = 15; j >= 1; j--) hist[k][j] = hist[k][j-1];
                hist[k][0] = dval(k);
                if (n[k] < 1000) n[k]++;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        dep[0] = 2;     dep[1] = 4;     dep[2] = 1;
        rv[0]  = 8'h00; rv[1]  = 8'h5A; rv[2]  = 8'h00;
        for (int k = 0; k < 3; k++) begin
            n[k] = 0;
            for (int j = 0; j < 16; j++) hist[k][j] = 8'h00;
        end

        // Reset for two edges while d is held non-zero.
        rst = 1'b1; da = 1'b1; db = 8'hFF; dc = 1'b1;
        @(negedge clk);
        tick(); tick();
        chk("rst_qa1", {7'b0, qa1}, 8'h00);
        chk("rst_qa2", {7'b0, qa2}, 8'h00);
        chk("rst_diffa", {7'b0, diffa}, 8'h00);
        chk("rst_filla", {7'b0, filla}, 8'h00);
        chk("rst_qb2", qb2, 8'h5A);

        // Single pulse on a, ramp on b.
        rst = 1'b0;
        da = 1'b0; db = 8'h11; tick();
        chk("fill_a_edge1", {7'b0, filla}, 8'h00);
        da = 1'b1; db = 8'h22; tick();
        chk("pulse_q1_hi", {7'b0, qa1}, 8'h01);
        chk("pulse_q2_lo", {7'b0, qa2}, 8'h00);
        chk("pulse_diff1", {7'b0, diffa}, 8'h01);
        chk("fill_a_edge2", {7'b0, filla}, 8'h01);
        da = 1'b0; db = 8'h33; tick();
        chk("pulse_q1_lo", {7'b0, qa1}, 8'h00);
        chk("pulse_q2_hi", {7'b0, qa2}, 8'h01);
        chk("pulse_diff2", {7'b0, diffa}, 8'h01);
        chk("b_q2_edge3", qb2, 8'h5A);
        db = 8'h44; tick();
        chk("pulse_q2_end", {7'b0, qa2}, 8'h00);
        chk("pulse_diff0", {7'b0, diffa}, 8'h00);
        chk("b_q2_edge4", qb2, 8'h11);
        chk("b_fill_edge4", {7'b0, fillb}, 8'h01);
        db = 8'h55; tick();
        chk("b_q1_edge5", qb1, 8'h55);
        chk("b_q2_edge5", qb2, 8'h22);

        // Alternating pattern on a; d is driven mid-period.
        begin
            logic [6:0] pat;
            pat = 7'b1010100;
            for (int i = 0; i < 7; i++) begin
                da = pat[i];
                db = $urandom_range(0, 255);
                dc = 1'($urandom);
                tick();
            end
        end

        // Random stimulus with glitches between edges and occasional resets.
        for (int i = 0; i < 300; i++) begin
            logic       sa, sc;
            logic [7:0] sb;
            rst = ($urandom_range(0, 31) == 0);
            sa  = 1'($urandom); sb = 8'($urandom); sc = 1'($urandom);
            da = ~sa; db = ~sb; dc = ~sc;
            #5;
            da = sa; db = sb; dc = sc;
            tick();
        end

        // Mid-stream reset after filling with ones, then refill.
        rst = 1'b0; da = 1'b1; db = 8'hFF; dc = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("ones_qa2", {7'b0, qa2}, 8'h01);
        chk("ones_qb2", qb2, 8'hFF);
        rst = 1'b1; tick();
        chk("mid_rst_qa1", {7'b0, qa1}, 8'h00);
        chk("mid_rst_qa2", {7'b0, qa2}, 8'h00);
        chk("mid_rst_filla", {7'b0, filla}, 8'h00);
        chk("mid_rst_qb1", qb1, 8'h5A);
        chk("mid_rst_qb2", qb2, 8'h5A);
        chk("mid_rst_fillb", {7'b0, fillb}, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("refill_qb2", qb2, 8'hFF);
        chk("refill_fillb", {7'b0, fillb}, 8'h01);

        // DEPTH=1 instance: random d, diff must never assert.
        for (int i = 0; i < 20; i++) begin
            dc = 1'($urandom);
            da = 1'($urandom);
            db = 8'($urandom);
            tick();
            chk("c_nodiff", {7'b0, diffc}, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
